// File: rtl/cpu_clk_ctrl.sv
// Run/pause/single-step controller producing a one-cycle CPU clock-enable in the clk_dis domain.
// Define CPU_CYCLE_CNT_EN to add the 32-bit cycle_cnt output counting issued cpu_ce pulses.

module cpu_clk_deb #(
    parameter int DEB_BITS = 20
) (
    input  logic clk_dis,
    input  logic rst,
    input  logic btn_i,
    output logic evt_o
);
    logic                s1_q, s2_q, deb_q, deb_prev_q;
    logic [DEB_BITS-1:0] cnt_q;

    // The level flips only after 2^DEB_BITS consecutive cycles of disagreement.
    always_ff @(posedge clk_dis or posedge rst) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= btn_i;
            s2_q       <= s1_q;
            deb_prev_q <= deb_q;
            if (s2_q != deb_q) begin
                if (&cnt_q) begin
                    deb_q <= s2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign evt_o = deb_q & ~deb_prev_q;
endmodule

module cpu_clk_ctrl #(
    parameter int RATE_SHIFT = 0,
    parameter int DEB_BITS   = 20
) (
    input  logic        clk_dis,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        run_btn,
    input  logic        step_btn,
    input  logic        cpu_halt,
    output logic        cpu_ce,
    output logic [1:0]  mode,
    output logic [2:0]  rate_idx,
    output logic        halted
`ifdef CPU_CYCLE_CNT_EN
    ,
    output logic [31:0] cycle_cnt
`endif
);
    localparam int unsigned CW = 30;
    localparam logic [4:0]  RS = 5'(RATE_SHIFT);

    typedef enum logic [1:0] {
        ST_PAUSE = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      rate_q, rate_d;
    logic            halted_q, halted_d;
    logic            ce_q, ce_d;
    logic            run_evt, step_evt;
    logic [2:0]      sel_idx;
    logic [4:0]      exp_w;
    logic [CW-1:0]   period_m1;
    logic            unused_sw;

    assign unused_sw = ^sw[9:0];

    cpu_clk_deb #(.DEB_BITS(DEB_BITS)) u_run_deb (
        .clk_dis(clk_dis), .rst(rst), .btn_i(run_btn), .evt_o(run_evt)
    );
    cpu_clk_deb #(.DEB_BITS(DEB_BITS)) u_step_deb (
        .clk_dis(clk_dis), .rst(rst), .btn_i(step_btn), .evt_o(step_evt)
    );

    always_comb begin
        if      (sw[15]) sel_idx = 3'd0;
        else if (sw[14]) sel_idx = 3'd1;
        else if (sw[13]) sel_idx = 3'd2;
        else if (sw[12]) sel_idx = 3'd3;
        else if (sw[11]) sel_idx = 3'd4;
        else if (sw[10]) sel_idx = 3'd5;
        else             sel_idx = 3'd6;
    end

    // Period derives from the latched index, so switch changes take effect only at latch points.
    assign exp_w     = (rate_q == 3'd6) ? 5'd19 : (5'd29 - {2'b00, rate_q});
    assign period_m1 = (CW'(1) << (exp_w - RS)) - CW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rate_d   = rate_q;
        halted_d = halted_q;
        ce_d     = 1'b0;
        case (state_q)
            ST_PAUSE: begin
                if (run_evt) begin
                    if (!cpu_halt) begin
                        state_d  = ST_RUN;
                        cnt_d    = '0;
                        rate_d   = sel_idx;
                        halted_d = 1'b0;
                    end
                end else if (step_evt) begin
                    state_d  = ST_STEP;
                    ce_d     = 1'b1;
                    halted_d = 1'b0;
                end
            end
            ST_STEP: state_d = ST_PAUSE;
            ST_RUN: begin
                // Leaving RUN takes priority over a terminal-count pulse.
                if (run_evt || cpu_halt) begin
                    state_d = ST_PAUSE;
                    cnt_d   = '0;
                    if (cpu_halt) halted_d = 1'b1;
                end else if (cnt_q == period_m1) begin
                    cnt_d  = '0;
                    ce_d   = 1'b1;
                    rate_d = sel_idx;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_PAUSE;
        endcase
    end

    always_ff @(posedge clk_dis or posedge rst) begin
        if (rst) begin
            state_q  <= ST_PAUSE;
            cnt_q    <= '0;
            rate_q   <= 3'd6;
            halted_q <= 1'b0;
            ce_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rate_q   <= rate_d;
            halted_q <= halted_d;
            ce_q     <= ce_d;
        end
    end

    assign cpu_ce   = ce_q;
    assign mode     = state_q;
    assign rate_idx = rate_q;
    assign halted   = halted_q;

`ifdef CPU_CYCLE_CNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk_dis or posedge rst) begin
        if (rst)       cyc_q <= '0;
        else if (ce_d) cyc_q <= cyc_q + 32'd1;
    end

    assign cycle_cnt = cyc_q;
`endif
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with RATE_SHIFT=17 (default period 4) and DEB_BITS=2.
module tb_cpu_clk_ctrl;
  logic        clk_dis = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw = '0;
  logic        run_btn = 1'b0;
  logic        step_btn = 1'b0;
  logic        cpu_halt = 1'b0;
  logic        cpu_ce;
  logic [1:0]  mode;
  logic [2:0]  rate_idx;
  logic        halted;
`ifdef CPU_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  int n_checks = 0;
  int n_fails = 0;
  int ce_seen = 0;
  int base;

  cpu_clk_ctrl #(.RATE_SHIFT(17), .DEB_BITS(2)) dut (
    .clk_dis(clk_dis), .rst(rst), .sw(sw), .run_btn(run_btn),
    .step_btn(step_btn), .cpu_halt(cpu_halt), .cpu_ce(cpu_ce),
    .mode(mode), .rate_idx(rate_idx), .halted(halted)
`ifdef CPU_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk_dis = ~clk_dis;

  // advance n active edges, sample 1 time unit later, accumulate observed pulses
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_dis);
      #1;
      if (cpu_ce === 1'b1) ce_seen++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // press a button long enough for one event (acts at edge 7), then release and let it settle
  task automatic press_run();
    run_btn = 1'b1;
    tick(7);
    run_btn = 1'b0;
    tick(8);
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_ce", 32'(cpu_ce), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_rate", 32'(rate_idx), 32'd6);
`ifdef CPU_CYCLE_CNT_EN
    chk("rst_cyc", cycle_cnt, 32'd0);
`endif
    rst = 1'b0;
    tick(2);

    // 1: run press, entry after 2+4+1 edges, period 4
    run_btn = 1'b1;
    tick(6);
    chk("t1_mode_before", 32'(mode), 32'd0);
    tick(1);
    chk("t1_mode_run", 32'(mode), 32'd1);
    chk("t1_rate", 32'(rate_idx), 32'd6);
    chk("t1_ce_entry", 32'(cpu_ce), 32'd0);
    tick(3);
    chk("t1_ce_early", 32'(cpu_ce), 32'd0);
    tick(1);
    chk("t1_ce_first", 32'(cpu_ce), 32'd1);
    tick(1);
    chk("t1_ce_drop", 32'(cpu_ce), 32'd0);
    run_btn = 1'b0;
    tick(3);
    chk("t1_ce_second", 32'(cpu_ce), 32'd1);

    // 2: rate change mid-period completes current period, then 4096
    tick(1);
    sw = 16'h8000;
    tick(2);
    chk("t2_ce_mid", 32'(cpu_ce), 32'd0);
    chk("t2_rate_old", 32'(rate_idx), 32'd6);
    tick(1);
    chk("t2_ce_end", 32'(cpu_ce), 32'd1);
    chk("t2_rate_new", 32'(rate_idx), 32'd0);
    base = ce_seen;
    tick(4095);
    chk("t2_no_early", 32'(ce_seen - base), 32'd0);
    tick(1);
    chk("t2_ce_4096", 32'(cpu_ce), 32'd1);
    sw = 16'h0000;
    press_run();
    chk("t2_pause", 32'(mode), 32'd0);
    chk("t2_halted", 32'(halted), 32'd0);

    // 3: three single steps
    base = ce_seen;
    for (int k = 0; k < 3; k++) begin
      step_btn = 1'b1;
      tick(6);
      chk("t3_mode_wait", 32'(mode), 32'd0);
      tick(1);
      chk("t3_mode_step", 32'(mode), 32'd2);
      chk("t3_ce_step", 32'(cpu_ce), 32'd1);
      tick(1);
      chk("t3_mode_back", 32'(mode), 32'd0);
      chk("t3_ce_back", 32'(cpu_ce), 32'd0);
      step_btn = 1'b0;
      tick(8);
    end
    chk("t3_pulses", 32'(ce_seen - base), 32'd3);

    // 4: halt on terminal count suppresses the pulse
    run_btn = 1'b1;
    tick(7);
    chk("t4_run", 32'(mode), 32'd1);
    chk("t4_rate", 32'(rate_idx), 32'd6);
    run_btn = 1'b0;
    base = ce_seen;
    tick(3);
    cpu_halt = 1'b1;
    tick(1);
    chk("t4_no_pulse", 32'(ce_seen - base), 32'd0);
    chk("t4_mode", 32'(mode), 32'd0);
    chk("t4_halted", 32'(halted), 32'd1);
    tick(8);
    press_run();
    chk("t4_blocked", 32'(mode), 32'd0);
    chk("t4_halted_held", 32'(halted), 32'd1);
    cpu_halt = 1'b0;

    // 5: short glitch is filtered; simultaneous run+step selects RUN
    run_btn = 1'b1;
    tick(3);
    run_btn = 1'b0;
    tick(10);
    chk("t5_glitch", 32'(mode), 32'd0);
    run_btn = 1'b1;
    step_btn = 1'b1;
    base = ce_seen;
    tick(7);
    chk("t5_both_run", 32'(mode), 32'd1);
    chk("t5_halted_clr", 32'(halted), 32'd0);
    tick(1);
    chk("t5_still_run", 32'(mode), 32'd1);
    chk("t5_no_step_ce", 32'(ce_seen - base), 32'd0);
    run_btn = 1'b0;
    step_btn = 1'b0;
    tick(8);

    // 6: fresh reset, ten pulses, then asynchronous reset mid-period
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick(1);
    run_btn = 1'b1;
    tick(7);
    chk("t6_run", 32'(mode), 32'd1);
    run_btn = 1'b0;
    base = ce_seen;
    tick(39);
`ifdef CPU_CYCLE_CNT_EN
    chk("t6_cyc9", cycle_cnt, 32'd9);
`endif
    tick(1);
    chk("t6_pulses", 32'(ce_seen - base), 32'd10);
`ifdef CPU_CYCLE_CNT_EN
    chk("t6_cyc10", cycle_cnt, 32'd10);
`endif
    tick(2);
    rst = 1'b1;
    #1;
    chk("t6_rst_mode", 32'(mode), 32'd0);
    chk("t6_rst_ce", 32'(cpu_ce), 32'd0);
    chk("t6_rst_rate", 32'(rate_idx), 32'd6);
    chk("t6_rst_halted", 32'(halted), 32'd0);
`ifdef CPU_CYCLE_CNT_EN
    chk("t6_rst_cyc", cycle_cnt, 32'd0);
`endif
    tick(2);
    chk("t6_rst_hold", 32'(mode), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
